// File: rtl/sw_pkg.sv
// Shared types and constants for the switch debouncer.
// Latency: n/a (package only).
// Backpressure: n/a; the debouncer is a free-running level conditioner.
package sw_pkg;

  // Per-channel qualification state: settled, or counting a candidate change.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } sw_state_t;

  // Production debounce window in clock cycles.
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Short window so simulations finish quickly.
  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: 2-flop synchroniser, stability counter FSM, rise/fall strobes.
// Latency: clean level moves on the (DEBOUNCE_CYCLES+2)th edge after the raw change is sampled.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
// Optional SW_DEBOUNCE_TOGGLE_EN adds a push-on/push-off level flipped by every rise.
module sw_debounce_chan
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,
  output logic sw_toggle
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  sw_state_t        state_q;
  sw_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_d;
  logic             rise_d;
  logic             fall_d;

  // Two-flop synchroniser; only s2 is allowed to reach the qualification logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Next-state logic. The first mismatch cycle is detected from STABLE and
  // already counts as cycle 1, so the counter loads 1 on entry to PENDING and
  // the level commits when the counter reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    clean_d = sw_clean;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s2 != sw_clean) begin
          state_d = ST_PENDING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (s2 == sw_clean) begin
          // Glitch rejected: drop the count, no output change.
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          clean_d = s2;
          rise_d  = s2;
          fall_d  = ~s2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  // State, counter, clean level and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      sw_clean <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_clean <= clean_d;
      sw_rise  <= rise_d;
      sw_fall  <= fall_d;
    end
  end

`ifdef SW_DEBOUNCE_TOGGLE_EN
  // Toggle flips on the same edge that raises sw_rise, so it adds no latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_toggle <= 1'b0;
    end else begin
      sw_toggle <= sw_toggle ^ rise_d;
    end
  end
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces NUM_SW independent slide switches into clean levels plus rise/fall strobes.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampling of a steady new raw level.
// Backpressure: none; outputs are levels and single-cycle strobes.
// Optional SW_DEBOUNCE_TOGGLE_EN adds the sw_toggle push-on/push-off outputs.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,
  output logic [NUM_SW-1:0] sw_toggle
`endif
);

  // Wide enough for 0..DEBOUNCE_CYCLES-1; the counter never wraps.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Reject configurations the counter scheme cannot support.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (NUM_SW < 1 || NUM_SW > 16) begin : g_bad_num
    $error("sw_debounce: NUM_SW must be in 1..16");
  end

  // One fully independent channel per switch.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    sw_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw    (sw_raw[i]),
      .sw_clean  (sw_clean[i]),
      .sw_rise   (sw_rise[i]),
      .sw_fall   (sw_fall[i])
`ifdef SW_DEBOUNCE_TOGGLE_EN
      ,
      .sw_toggle (sw_toggle[i])
`endif
    );
  end

endmodule
